// File: rtl/dpa_pkg.sv
// Shared DPA definitions: image-memory geometry, requester indices and the
// arbiter state encoding used by the IM port arbiter and its picker.
package dpa_pkg;

    localparam int NREQ = 3;
    localparam int AW   = 20;
    localparam int DW   = 24;
    localparam int IDXW = 2;

    localparam logic [IDXW-1:0] REQ_HDR   = 2'd0;
    localparam logic [IDXW-1:0] REQ_CLK   = 2'd1;
    localparam logic [IDXW-1:0] REQ_PHOTO = 2'd2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic logic [NREQ-1:0] idxToOnehot(input logic [IDXW-1:0] idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/im_arb_pick.sv
// Combinational one-hot requester picker. IM_ARB_RR_EN selects round-robin
// (search from pointer+1, wrapping); otherwise the lowest index wins.
module im_arb_pick
    import dpa_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
`ifdef IM_ARB_RR_EN
    input  logic [IDXW-1:0] i_ptr,
`endif
    output logic [NREQ-1:0] o_gnt,
    output logic [IDXW-1:0] o_idx,
    output logic            o_valid
);

`ifdef IM_ARB_RR_EN
    logic [IDXW:0]   w_sum;
    logic [IDXW-1:0] w_cand;

    // First asserted request after the last winner takes the beat.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, i_ptr} + (IDXW+1)'(k);
            if (w_sum >= (IDXW+1)'(NREQ)) begin
                w_sum = w_sum - (IDXW+1)'(NREQ);
            end
            w_cand = w_sum[IDXW-1:0];
            if (!o_valid && i_req[w_cand]) begin
                o_gnt   = idxToOnehot(w_cand);
                o_idx   = w_cand;
                o_valid = 1'b1;
            end
        end
    end
`else
    logic [IDXW-1:0] w_cand;

    // Scanning downwards lets the lowest asserted index overwrite the rest.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = IDXW'(k);
            if (i_req[w_cand]) begin
                o_gnt   = idxToOnehot(w_cand);
                o_idx   = w_cand;
                o_valid = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/im_port_arbiter.sv
// Single-port image-memory arbiter with burst locking and a 3-cycle read
// return. IM_ARB_RR_EN enables the round-robin picker and its pointer.
module im_port_arbiter
    import dpa_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ-1:0]      i_we,
    input  logic [NREQ-1:0]      i_lock,
    input  logic [NREQ*AW-1:0]   i_addr,
    input  logic [NREQ*DW-1:0]   i_wdata,
    output logic [NREQ-1:0]      o_gnt,
    output logic [NREQ-1:0]      o_rvalid,
    output logic [DW-1:0]        o_rdata,
    output logic [IDXW-1:0]      o_owner,
    output logic                 o_locked,
    output logic [AW-1:0]        o_IM_A,
    output logic [DW-1:0]        o_IM_D,
    output logic                 o_IM_WEN,
    input  logic [DW-1:0]        i_IM_Q
);

    arb_state_e      r_state;
    arb_state_e      w_nextState;
    logic [IDXW-1:0] r_owner;
    logic [IDXW-1:0] w_nextOwner;

    logic [NREQ-1:0] w_pickGnt;
    logic [IDXW-1:0] w_pickIdx;
    logic            w_pickValid;

    logic [NREQ-1:0] w_gnt;
    logic [IDXW-1:0] w_gntIdx;
    logic            w_gntValid;
    logic            w_gntWe;

    logic [AW-1:0]   w_addrArr  [NREQ];
    logic [DW-1:0]   w_wdataArr [NREQ];

    logic            r_rd1Valid;
    logic            r_rd2Valid;
    logic [IDXW-1:0] r_rd1Idx;
    logic [IDXW-1:0] r_rd2Idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addrArr[g]  = i_addr[g*AW +: AW];
        assign w_wdataArr[g] = i_wdata[g*DW +: DW];
    end

`ifdef IM_ARB_RR_EN
    logic [IDXW-1:0] r_ptr;

    im_arb_pick u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pickGnt),
        .o_idx   (w_pickIdx),
        .o_valid (w_pickValid)
    );

    // The pointer only moves on free arbitration, never during a locked burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= IDXW'(NREQ - 1);
        end else if (r_state == IDLE && w_gntValid) begin
            r_ptr <= w_gntIdx;
        end
    end
`else
    im_arb_pick u_pick (
        .i_req   (i_req),
        .o_gnt   (w_pickGnt),
        .o_idx   (w_pickIdx),
        .o_valid (w_pickValid)
    );
`endif

    // Ownership is taken only with a granted beat and released on the owner's first lock=0 cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextOwner = r_owner;
        w_gnt       = '0;
        w_gntIdx    = r_owner;
        w_gntValid  = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (w_pickValid) begin
                        w_gnt      = w_pickGnt;
                        w_gntIdx   = w_pickIdx;
                        w_gntValid = 1'b1;
                        if (i_lock[w_pickIdx]) begin
                            w_nextState = LOCKED;
                            w_nextOwner = w_pickIdx;
                        end
                    end
                end
                LOCKED: begin
                    if (i_req[r_owner]) begin
                        w_gnt      = idxToOnehot(r_owner);
                        w_gntValid = 1'b1;
                    end
                    if (!i_lock[r_owner]) begin
                        w_nextState = IDLE;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    assign w_gntWe  = i_we[w_gntIdx];
    assign o_gnt    = w_gnt;
    assign o_owner  = r_owner;
    assign o_locked = (r_state == LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= '0;
        end else begin
            r_state <= w_nextState;
            r_owner <= w_nextOwner;
        end
    end

    // Memory pins: write data is only refreshed on write beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_IM_A   <= '0;
            o_IM_D   <= '0;
            o_IM_WEN <= 1'b1;
        end else if (w_gntValid) begin
            o_IM_A   <= w_addrArr[w_gntIdx];
            o_IM_WEN <= ~w_gntWe;
            if (w_gntWe) begin
                o_IM_D <= w_wdataArr[w_gntIdx];
            end
        end else begin
            o_IM_WEN <= 1'b1;
        end
    end

    // Read return: two tracking stages line up with the memory's registered IM_Q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd1Valid <= 1'b0;
            r_rd1Idx   <= '0;
            r_rd2Valid <= 1'b0;
            r_rd2Idx   <= '0;
            o_rvalid   <= '0;
            o_rdata    <= '0;
        end else begin
            r_rd1Valid <= w_gntValid && !w_gntWe;
            r_rd1Idx   <= w_gntIdx;
            r_rd2Valid <= r_rd1Valid;
            r_rd2Idx   <= r_rd1Idx;
            o_rvalid   <= r_rd2Valid ? idxToOnehot(r_rd2Idx) : '0;
            if (r_rd2Valid) begin
                o_rdata <= i_IM_Q;
            end
        end
    end

endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed bench for im_port_arbiter: read beats push expected returns into a
// scoreboard that a negedge monitor drains whenever rvalid is seen.
module tb_im_port_arbiter;
    import dpa_pkg::*;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      we;
    logic [NREQ-1:0]      lock;
    logic [NREQ*AW-1:0]   addrBus;
    logic [NREQ*DW-1:0]   wdataBus;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rvalid;
    logic [DW-1:0]        rdata;
    logic [IDXW-1:0]      owner;
    logic                 locked;
    logic [AW-1:0]        imA;
    logic [DW-1:0]        imD;
    logic                 imWen;
    logic [DW-1:0]        imQ;

    typedef struct {
        logic [IDXW-1:0] idx;
        logic [DW-1:0]   data;
        int              due;
    } exp_t;

    exp_t            sb[$];
    exp_t            monEntry;
    logic [DW-1:0]   mem [logic [AW-1:0]];
    int              total   = 0;
    int              bad     = 0;
    int              rvCount = 0;
    int              rvBase  = 0;
    int              cyc     = 0;
    logic [IDXW-1:0] gExp;

    im_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (req),
        .i_we     (we),
        .i_lock   (lock),
        .i_addr   (addrBus),
        .i_wdata  (wdataBus),
        .o_gnt    (gnt),
        .o_rvalid (rvalid),
        .o_rdata  (rdata),
        .o_owner  (owner),
        .o_locked (locked),
        .o_IM_A   (imA),
        .o_IM_D   (imD),
        .o_IM_WEN (imWen),
        .i_IM_Q   (imQ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] initVal(input logic [AW-1:0] a);
        case (a)
            20'h00002: return 24'h0A0B0C;
            20'h00010: return 24'h445566;
            20'h00100: return 24'hAA0000;
            20'h00101: return 24'hAA0001;
            20'h00102: return 24'hAA0002;
            20'h00200: return 24'h0C1C2C;
            20'h00201: return 24'h0D0D0D;
            20'h00202: return 24'h0E0E0E;
            default:   return '0;
        endcase
    endfunction

    // Synchronous single-port memory: address registered by the DUT, data out one cycle later.
    always @(posedge clk) begin
        imQ <= mem.exists(imA) ? mem[imA] : initVal(imA);
        if (!imWen) mem[imA] = imD;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid pops one expected read; overdue entries count as missing.
    always @(negedge clk) begin
        if (rvalid != '0) begin
            rvCount++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected rvalid: got rvalid=%b rdata=0x%0h, want none (cycle %0d)", rvalid, rdata, cyc);
            end else begin
                monEntry = sb.pop_front();
                checkOutput("rvalid", 32'(rvalid), 32'(NREQ'(1) << monEntry.idx));
                checkOutput("rdata", 32'(rdata), 32'(monEntry.data));
                checkOutput("read latency", cyc, monEntry.due);
            end
        end else if (sb.size() != 0 && sb[0].due < cyc) begin
            monEntry = sb.pop_front();
            total++;
            bad++;
            $display("[TB] FAIL missing rvalid: got none, want req %0d data 0x%0h by cycle %0d", monEntry.idx, monEntry.data, monEntry.due);
        end
    end

    task automatic applyStimulus(input logic [IDXW-1:0] idx, input logic r, input logic w,
                                 input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[idx]              = r;
        we[idx]               = w;
        lock[idx]             = l;
        addrBus[idx*AW +: AW]  = a;
        wdataBus[idx*DW +: DW] = d;
    endtask

    task automatic pushRead(input logic [IDXW-1:0] idx, input logic [DW-1:0] d);
        sb.push_back('{idx: idx, data: d, due: cyc + 3});
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic checkGnt(input string name, input logic [NREQ-1:0] exp);
        @(negedge clk);
        checkOutput(name, 32'(gnt), 32'(exp));
    endtask

    task automatic clearInputs;
        req      = '0;
        we       = '0;
        lock     = '0;
        addrBus  = '0;
        wdataBus = '0;
    endtask

    task automatic contention(input int beats);
        applyStimulus(REQ_HDR,   1'b1, 1'b0, 1'b0, 20'h00100, '0);
        applyStimulus(REQ_CLK,   1'b1, 1'b0, 1'b0, 20'h00101, '0);
        applyStimulus(REQ_PHOTO, 1'b1, 1'b0, 1'b0, 20'h00102, '0);
        for (int k = 0; k < beats; k++) begin
`ifdef IM_ARB_RR_EN
            gExp = IDXW'(k % NREQ);
`else
            gExp = REQ_HDR;
`endif
            pushRead(gExp, 24'hAA0000 + DW'(gExp));
            checkGnt("contention gnt", NREQ'(1) << gExp);
            nextCycle();
        end
        clearInputs();
    endtask

    initial begin
        clearInputs();
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req = '1;
        #1;
        checkOutput("gnt in reset", 32'(gnt), 32'h0);
        checkOutput("reset IM_WEN", 32'(imWen), 32'h1);
        checkOutput("reset IM_A", 32'(imA), 32'h0);
        checkOutput("reset IM_D", 32'(imD), 32'h0);
        checkOutput("reset rvalid", 32'(rvalid), 32'h0);
        checkOutput("reset rdata", 32'(rdata), 32'h0);
        checkOutput("reset locked", 32'(locked), 32'h0);
        checkOutput("reset owner", 32'(owner), 32'h0);
        clearInputs();
        reset = 1'b0;
        nextCycle();

        contention(6);
        repeat (4) nextCycle();

        applyStimulus(REQ_HDR, 1'b1, 1'b0, 1'b0, 20'h00002, '0);
        pushRead(REQ_HDR, 24'h0A0B0C);
        checkGnt("single read gnt", 3'b001);
        nextCycle();
        clearInputs();
        checkOutput("single read IM_A", 32'(imA), 32'h00002);
        checkOutput("single read IM_WEN", 32'(imWen), 32'h1);
        repeat (4) nextCycle();

        applyStimulus(REQ_PHOTO, 1'b1, 1'b1, 1'b1, 20'hE0001, 24'h000001);
        checkGnt("burst gnt", 3'b100);
        for (int k = 1; k <= 3; k++) begin
            nextCycle();
            checkOutput("burst IM_A", 32'(imA), 32'h000E0000 + 32'(k));
            checkOutput("burst IM_WEN", 32'(imWen), 32'h0);
            checkOutput("burst locked", 32'(locked), 32'h1);
            checkOutput("burst owner", 32'(owner), 32'h2);
            applyStimulus(REQ_PHOTO, 1'b1, 1'b1, (k < 3), 20'hE0001 + AW'(k), DW'(k + 1));
            applyStimulus(REQ_CLK, 1'b1, 1'b0, 1'b0, 20'h00200, '0);
            checkGnt("burst gnt", 3'b100);
        end
        nextCycle();
        checkOutput("burst IM_A", 32'(imA), 32'h000E0004);
        checkOutput("burst IM_WEN", 32'(imWen), 32'h0);
        checkOutput("burst unlocked", 32'(locked), 32'h0);
        applyStimulus(REQ_PHOTO, 1'b0, 1'b0, 1'b0, '0, '0);
        pushRead(REQ_CLK, 24'h0C1C2C);
        checkGnt("burst handoff gnt", 3'b010);
        nextCycle();
        clearInputs();
        repeat (3) nextCycle();

        applyStimulus(REQ_HDR, 1'b1, 1'b1, 1'b1, 20'h00300, 24'h0000AA);
        checkGnt("idle-lock gnt", 3'b001);
        nextCycle();
        applyStimulus(REQ_HDR, 1'b0, 1'b1, 1'b1, 20'h00300, 24'h0000AA);
        applyStimulus(REQ_CLK, 1'b1, 1'b0, 1'b0, 20'h00201, '0);
        applyStimulus(REQ_PHOTO, 1'b1, 1'b0, 1'b0, 20'h00202, '0);
        checkOutput("idle-lock write WEN", 32'(imWen), 32'h0);
        checkGnt("idle-lock hold gnt", 3'b000);
        nextCycle();
        checkOutput("idle-lock IM_WEN", 32'(imWen), 32'h1);
        checkOutput("idle-lock IM_A", 32'(imA), 32'h00300);
        checkOutput("idle-lock locked", 32'(locked), 32'h1);
        checkGnt("idle-lock hold gnt", 3'b000);
        nextCycle();
        checkOutput("idle-lock IM_WEN", 32'(imWen), 32'h1);
        checkOutput("idle-lock IM_A", 32'(imA), 32'h00300);
        applyStimulus(REQ_HDR, 1'b1, 1'b1, 1'b0, 20'h00301, 24'h0000BB);
        checkGnt("idle-lock final gnt", 3'b001);
        nextCycle();
        applyStimulus(REQ_HDR, 1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("idle-lock final IM_A", 32'(imA), 32'h00301);
        checkOutput("idle-lock final WEN", 32'(imWen), 32'h0);
        pushRead(REQ_CLK, 24'h0D0D0D);
        checkGnt("idle-lock release gnt", 3'b010);
        nextCycle();
        applyStimulus(REQ_CLK, 1'b0, 1'b0, 1'b0, '0, '0);
        pushRead(REQ_PHOTO, 24'h0E0E0E);
        checkGnt("idle-lock next gnt", 3'b100);
        nextCycle();
        clearInputs();
        repeat (5) nextCycle();

        rvBase = rvCount;
        applyStimulus(REQ_CLK, 1'b1, 1'b0, 1'b1, 20'h00010, '0);
        pushRead(REQ_CLK, 24'h445566);
        checkGnt("mixed read gnt", 3'b010);
        nextCycle();
        applyStimulus(REQ_CLK, 1'b1, 1'b1, 1'b1, 20'h00010, 24'h112233);
        checkGnt("mixed write gnt", 3'b010);
        nextCycle();
        applyStimulus(REQ_CLK, 1'b1, 1'b0, 1'b0, 20'h00010, '0);
        pushRead(REQ_CLK, 24'h112233);
        checkGnt("mixed readback gnt", 3'b010);
        nextCycle();
        clearInputs();
        repeat (5) nextCycle();
        checkOutput("mixed rvalid pulses", rvCount - rvBase, 2);

        rvBase = rvCount;
        applyStimulus(REQ_HDR, 1'b1, 1'b0, 1'b1, 20'h00002, '0);
        checkGnt("pre-reset read gnt", 3'b001);
        nextCycle();
        applyStimulus(REQ_HDR, 1'b1, 1'b1, 1'b1, 20'h00401, 24'h0000CC);
        checkGnt("pre-reset write gnt", 3'b001);
        nextCycle();
        checkOutput("pre-reset IM_WEN", 32'(imWen), 32'h0);
        reset = 1'b1;
        #1;
        checkOutput("async reset IM_WEN", 32'(imWen), 32'h1);
        checkOutput("async reset IM_A", 32'(imA), 32'h0);
        checkOutput("async reset IM_D", 32'(imD), 32'h0);
        checkOutput("async reset gnt", 32'(gnt), 32'h0);
        checkOutput("async reset locked", 32'(locked), 32'h0);
        checkOutput("async reset rdata", 32'(rdata), 32'h0);
        clearInputs();
        repeat (2) nextCycle();
        reset = 1'b0;
        repeat (5) nextCycle();
        checkOutput("post-reset rvalid pulses", rvCount - rvBase, 0);

        contention(3);
        repeat (8) nextCycle();
        checkOutput("scoreboard empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/im_port_arbiter.md
# im_port_arbiter

Arbitrates the single-port image memory (IM) of the DPA design between several internal requesters: header/table reader, photo transfer engine and digital-clock overlay renderer. The block accepts one read or write beat per cycle from the winning requester and drives the registered IM address, data and write-enable pins. It returns read data to the originating requester with a fixed latency. A per-requester lock keeps ownership across multi-beat bursts, so a photo row copy is never interleaved with clock-digit writes.

## Interface
- NREQ, 3, number of requesters; index 0 = header reader, 1 = clock renderer, 2 = photo engine
- AW, 20, IM address width
- DW, 24, IM data width (RGB888)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  beat request per requester
- we  in  NREQ  1 = write beat, 0 = read beat
- lock  in  NREQ  hold ownership after the current beat
- addr  in  NREQ*AW  packed beat addresses, requester i at [i*AW +: AW]
- wdata  in  NREQ*DW  packed write data
- gnt  out  NREQ  one-hot, combinational; beat accepted this cycle
- rvalid  out  NREQ  one-hot; rdata belongs to this requester
- rdata  out  DW  registered copy of IM_Q
- owner  out  2  current lock owner index, valid when locked=1
- locked  out  1  a lock is held
- IM_A  out  AW  memory address, registered
- IM_D  out  DW  memory write data, registered
- IM_WEN  out  1  active-low write enable, registered
- IM_Q  in  DW  memory read data

## Operation
- States:
  - IDLE: no owner. Arbitrate among asserted req.
  - LOCKED: only the owner may be granted.
- IDLE -> LOCKED: a beat is granted with lock[i]=1. The owner register captures i.
- LOCKED -> IDLE: first cycle in which the owner has lock=0.
  - If the owner also has req=1 in that cycle, its final beat is granted in that cycle.
- In LOCKED, owner req=0 is an idle cycle: IM_WEN=1, IM_A holds its previous value, other requesters stay ungranted.
- Granted beat, registered at the clock edge:
  - IM_A <= addr[i]
  - IM_D <= wdata[i] if we[i]=1; IM_D otherwise holds its value
  - IM_WEN <= ~we[i]
- No grant: IM_WEN <= 1. IM_A and IM_D hold.
- Read return: a 2-bit pipeline tracks (valid, index) per issued read beat. Writes issue no rvalid.
- Exactly one gnt bit, or none, in every cycle. gnt is never asserted to a requester with req=0.
- Simultaneous requests in IDLE go through the picker (see Configuration).
- Lock held with req=0 from the cycle it is first asserted: no ownership is taken. Lock is captured only together with a granted beat.

## Timing
- Beat granted in cycle t -> IM_A/IM_WEN valid in cycle t+1.
- IM_Q is valid in cycle t+2, and is registered into rdata with rvalid[i] asserted in cycle t+3. Read latency from grant to rvalid is 3 cycles.
- Throughput: 1 beat/cycle, including back-to-back read/write mixes from the same owner.
- Reset values:
  - IM_A=0, IM_D=0, IM_WEN=1
  - gnt=0 (combinationally, while reset is asserted), rvalid=0, rdata=0
  - owner=0, locked=0
  - state IDLE, round-robin pointer=NREQ-1
- Reset mid-burst: any in-flight rvalid is discarded. No write is issued after reset asserts, because IM_WEN goes to 1 asynchronously.
- Write in cycle t followed by a read of the same address in cycle t+1: the read returns the new data. This is a memory property; the block does not forward.

## Configuration
- IM_ARB_RR_EN defined: round-robin picker. Search starts at pointer+1 and wraps modulo NREQ. The pointer updates to the granted index on every IDLE-state grant.
- IM_ARB_RR_EN undefined: fixed priority, lowest index wins. No pointer register exists.
- Lock behaviour is identical in both builds.

## Structure
- Shared package dpa_pkg holds:
  - AW, DW and NREQ constants
  - requester index constants REQ_HDR=0, REQ_CLK=1, REQ_PHOTO=2
  - state enum (IDLE, LOCKED)
- One sub-module, im_arb_pick: combinational one-hot picker, with the round-robin pointer input present only under IM_ARB_RR_EN.
- The top level holds the state register, owner register, output registers and read-return pipeline.

## Test plan
- Single read, to confirm read latency:
  - Stimulus: requester 0 reads addr 0x00002 with IM_Q model returning 0x0A0B0C.
  - Required response: gnt[0] in cycle t; IM_A=0x00002 and IM_WEN=1 in t+1; rvalid[0] and rdata=0x0A0B0C in t+3.
- Contention:
  - Stimulus: all three req=1, lock=0, for 6 cycles.
  - Required response with IM_ARB_RR_EN: grants 0,1,2,0,1,2.
  - Required response without IM_ARB_RR_EN: grants 0 for 6 cycles.
- Lock burst:
  - Stimulus: requester 2 writes 4 beats to 0xE0001..0xE0004 with lock=1, while requester 1 requests continuously.
  - Required response: gnt[1] stays 0 until requester 2 drops lock, and IM_WEN=0 for 4 consecutive cycles.
- Owner idle while locked:
  - Stimulus: the owner drops req for 2 cycles while keeping lock.
  - Required response: IM_WEN=1 and no gnt to others for those 2 cycles.
- Reset mid-burst:
  - Stimulus: assert reset one cycle after a read grant.
  - Required response: no rvalid appears; outputs return to reset values, with IM_WEN=1 immediately.
- Mixed traffic:
  - Stimulus: read 0x00010, write 0x00010=0x112233, then read 0x00010 back-to-back from one owner.
  - Required response: the second rvalid returns 0x112233, and exactly 2 rvalid pulses occur.
